// File: rtl/data_sampling_mv.sv
// -----------------------------------------------------------------------------
// data_sampling_mv
//   Majority-vote bit sampler for the UART RX path. NUM_SAMPLES readings of
//   rx_in are taken around the middle of each bit, where the middle is
//   prescale/2. The voted value is presented with a one-cycle ready strobe,
//   a flag for non-unanimous samples, and a flag for unusable prescale values.
//
//   Optional feature: define RX_SYNC_EN to pass rx_in through a 2-flop
//   synchroniser (reset to idle-high) before voting.
//
// Parameters
//   PRESCALE_W   width of prescale / edge_cnt
//   NUM_SAMPLES  samples per bit (odd, 1..15)
//
// Ports
//   clk          RX oversampling clock
//   rst          asynchronous reset, active low
//   rx_in        serial line, idle high
//   dat_samp_en  sampling enable from the RX FSM
//   prescale     clocks per bit, stable while dat_samp_en=1
//   edge_cnt     position within the current bit, 0..prescale-1
//   sampled_bit  voted bit value, valid while smpl_ready=1, held otherwise
//   smpl_ready   one-cycle strobe: a new sampled_bit is available
//   noise_err    the samples of the last voted bit were not unanimous
//   cfg_err      prescale too small for the sample window; sampling inhibited
// -----------------------------------------------------------------------------
module data_sampling_mv #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  dat_samp_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  smpl_ready,
    output logic                  noise_err,
    output logic                  cfg_err
);

    localparam int K     = (NUM_SAMPLES - 1) / 2;
    localparam int MIN_P = 2 * K + 4;
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam int PW1   = PRESCALE_W + 1;

    localparam logic [CNT_W-1:0] K_C   = CNT_W'(K);
    localparam logic [CNT_W-1:0] ALL_C = CNT_W'(NUM_SAMPLES);

    // ------------------------------------------------------------------
    // Optional input synchroniser
    // ------------------------------------------------------------------
    logic rx_s;

`ifdef RX_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Both stages reset to the idle line level so no false start bit appears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;
`else
    assign rx_s = rx_in;
`endif

    // ------------------------------------------------------------------
    // Sample window geometry (one extra bit so nothing wraps)
    // ------------------------------------------------------------------
    logic [PW1-1:0] edge_ext;
    logic [PW1-1:0] ctr;
    logic [PW1-1:0] win_lo;
    logic [PW1-1:0] win_last;
    logic           cfg_bad;
    logic           in_win;
    logic           at_last;

    assign edge_ext = {1'b0, edge_cnt};
    assign ctr      = {1'b0, prescale} >> 1;
    // With a legal prescale, ctr >= K+2, so win_lo cannot underflow and
    // win_last stays strictly below prescale.
    assign win_lo   = ctr - PW1'(K);
    assign win_last = ctr + PW1'(K);
    assign cfg_bad  = ({1'b0, prescale} < PW1'(MIN_P));
    assign in_win   = (edge_ext >= win_lo) && (edge_ext < win_last);
    assign at_last  = (edge_ext == win_last);

    // ------------------------------------------------------------------
    // Vote state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] ones_q, ones_d;
    logic             bit_q, bit_d;
    logic             ready_q, ready_d;
    logic             noise_q, noise_d;
    logic             cfg_q, cfg_d;
    logic [CNT_W-1:0] sum;

    // Total ones including the sample taken at the last window position.
    assign sum = ones_q + CNT_W'(rx_s);

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // through this block can leave one unassigned and infer a latch.
        ones_d  = ones_q;
        bit_d   = bit_q;
        noise_d = noise_q;
        ready_d = 1'b0;
        cfg_d   = cfg_bad;

        if (!dat_samp_en || cfg_bad) begin
            // Partial windows are discarded; the voted outputs hold.
            ones_d = '0;
        end else if (at_last) begin
            bit_d   = (sum > K_C);
            noise_d = (sum != '0) && (sum != ALL_C);
            ready_d = 1'b1;
            ones_d  = '0;
        end else if (in_win) begin
            ones_d = sum;
        end else if (edge_ext == '0) begin
            // Recovers from an edge counter that skipped past the last sample.
            ones_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_q  <= '0;
            bit_q   <= 1'b1;
            ready_q <= 1'b0;
            noise_q <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            ones_q  <= ones_d;
            bit_q   <= bit_d;
            ready_q <= ready_d;
            noise_q <= noise_d;
            cfg_q   <= cfg_d;
        end
    end

    assign sampled_bit = bit_q;
    assign smpl_ready  = ready_q;
    assign noise_err   = noise_q;
    assign cfg_err     = cfg_q;

endmodule

// File: tb/tb_data_sampling_mv.sv
// -----------------------------------------------------------------------------
// tb_data_sampling_mv
//   Bench for data_sampling_mv in its default build (rx_in used directly).
//   Two instances share the same stimulus: NUM_SAMPLES=3 and NUM_SAMPLES=5.
//   Each table vector gives the inputs applied before a clock edge and the
//   outputs expected just after that edge.
// -----------------------------------------------------------------------------
module tb_data_sampling_mv;

    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          en;
    logic [PW-1:0] prescale;
    logic [PW-1:0] edge_cnt;

    logic bit3, rdy3, noise3, cfg3;
    logic bit5, rdy5, noise5, cfg5;

    data_sampling_mv #(.PRESCALE_W(PW), .NUM_SAMPLES(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .dat_samp_en (en),
        .prescale    (prescale),
        .edge_cnt    (edge_cnt),
        .sampled_bit (bit3),
        .smpl_ready  (rdy3),
        .noise_err   (noise3),
        .cfg_err     (cfg3)
    );

    data_sampling_mv #(.PRESCALE_W(PW), .NUM_SAMPLES(5)) dut5 (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .dat_samp_en (en),
        .prescale    (prescale),
        .edge_cnt    (edge_cnt),
        .sampled_bit (bit5),
        .smpl_ready  (rdy5),
        .noise_err   (noise5),
        .cfg_err     (cfg5)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic en_v, input int p, input int e, input logic rx_v);
        en       = en_v;
        prescale = PW'(p);
        edge_cnt = PW'(e);
        rx_in    = rx_v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic en_v, input int p, input int e, input logic rx_v);
        drive(en_v, p, e, rx_v);
        tick();
    endtask

    // ------------------------------------------------------------------
    // Vector table (NUM_SAMPLES=3 instance)
    // ------------------------------------------------------------------
    typedef struct {
        logic en;
        int   p;
        int   e;
        logic rx;
        logic rdy;
        logic bit_v;
        logic noise;
        logic cfg;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic en_v, input int p, input int e, input logic rx_v,
                           input logic rdy, input logic bit_v, input logic noise, input logic cfg);
        vec_t v;
        v.en = en_v; v.p = p; v.e = e; v.rx = rx_v;
        v.rdy = rdy; v.bit_v = bit_v; v.noise = noise; v.cfg = cfg;
        vecs.push_back(v);
    endtask

    // ------------------------------------------------------------------
    // Reference model: collects the in-window samples of each bit and
    // votes on them when the last window position is reached.
    // ------------------------------------------------------------------
    int   m_n[2] = '{3, 5};
    logic m_bit[2], m_noise[2], m_rdy[2], m_cfg[2];
    logic samp[2][16];
    int   nsamp[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_bit[i] = 1'b1; m_noise[i] = 1'b0; m_rdy[i] = 1'b0; m_cfg[i] = 1'b0;
            nsamp[i] = 0;
        end
    endtask

    task automatic model_step(input logic en_v, input int p, input int e, input logic rx_v);
        for (int i = 0; i < 2; i++) begin
            int k;
            int mid;
            int ones;
            k        = (m_n[i] - 1) / 2;
            mid      = p / 2;
            m_cfg[i] = (p < 2 * k + 4);
            m_rdy[i] = 1'b0;
            if (!en_v || m_cfg[i]) begin
                nsamp[i] = 0;
            end else if (e >= mid - k && e <= mid + k) begin
                if (nsamp[i] < 16) begin
                    samp[i][nsamp[i]] = rx_v;
                    nsamp[i]++;
                end
                if (e == mid + k) begin
                    ones = 0;
                    for (int j = 0; j < nsamp[i]; j++) ones += int'(samp[i][j]);
                    m_bit[i]   = (2 * ones > m_n[i]);
                    m_noise[i] = (ones != 0) && (ones != m_n[i]);
                    m_rdy[i]   = 1'b1;
                    nsamp[i]   = 0;
                end
            end else if (e == 0) begin
                nsamp[i] = 0;
            end
        end
    endtask

    initial begin
        // Table: three P=8 bits. Window 3..5, strobe visible after the e=5 edge.
        for (int e = 0; e < 8; e++)          // all zeros: clean 0
            add_vec(1'b1, 8, e, 1'b0, e == 5, e < 5, 1'b0, 1'b0);
        for (int e = 0; e < 8; e++)          // single 1 at e=4: 0 with noise
            add_vec(1'b1, 8, e, e == 4, e == 5, 1'b0, e >= 5, 1'b0);
        for (int e = 0; e < 8; e++)          // all ones: clean 1
            add_vec(1'b1, 8, e, 1'b1, e == 5, e >= 5, e < 5, 1'b0);

        // Reset state
        rst = 1'b0;
        drive(1'b0, 8, 0, 1'b1);
        #12;
        check("reset_bit",   bit3,   1'b1);
        check("reset_ready", rdy3,   1'b0);
        check("reset_noise", noise3, 1'b0);
        check("reset_cfg",   cfg3,   1'b0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].p, vecs[i].e, vecs[i].rx);
            check($sformatf("tbl%0d_ready", i), rdy3,   vecs[i].rdy);
            check($sformatf("tbl%0d_bit",   i), bit3,   vecs[i].bit_v);
            check($sformatf("tbl%0d_noise", i), noise3, vecs[i].noise);
            check($sformatf("tbl%0d_cfg",   i), cfg3,   vecs[i].cfg);
        end

        // Enable dropped mid-bit, then a full enabled bit of ones.
        for (int e = 0; e < 8; e++) step(1'b1, 8, e, 1'b0);
        check("pre_drop_bit", bit3, 1'b0);
        for (int e = 0; e < 8; e++) begin
            step(e < 4, 8, e, 1'b0);
            check($sformatf("drop_no_ready_e%0d", e), rdy3, 1'b0);
        end
        check("drop_bit_held", bit3, 1'b0);
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 8, e, 1'b1);
            if (e == 5) begin
                check("reen_ready", rdy3,   1'b1);
                check("reen_bit",   bit3,   1'b1);
                check("reen_noise", noise3, 1'b0);
            end
        end

        // Five-sample instance, P=16: window 6..10, pattern 1,0,1,0,1.
        for (int e = 0; e < 16; e++) step(1'b1, 16, e, 1'b0);
        check("n5_pre_bit", bit5, 1'b0);
        for (int e = 0; e < 16; e++) begin
            step(1'b1, 16, e, (e == 6 || e == 8 || e == 10));
            if (e == 9)  check("n5_ready_early", rdy5, 1'b0);
            if (e == 10) begin
                check("n5_ready", rdy5,   1'b1);
                check("n5_bit",   bit5,   1'b1);
                check("n5_noise", noise5, 1'b1);
            end
            if (e == 11) check("n5_ready_once", rdy5, 1'b0);
        end
        // Same bit on the three-sample instance: window 7..9 saw 0,1,0.
        check("n3_p16_bit",   bit3,   1'b0);
        check("n3_p16_noise", noise3, 1'b1);

        // Illegal prescale: P=5 is below 2*1+4 for three samples.
        step(1'b1, 5, 0, 1'b1);
        check("cfg_set", cfg3, 1'b1);
        for (int b = 0; b < 3; b++) begin
            for (int e = 0; e < 5; e++) begin
                step(1'b1, 5, e, 1'b1);
                check($sformatf("cfg_no_ready_b%0d_e%0d", b, e), rdy3, 1'b0);
            end
        end
        check("cfg_bit_held",   bit3,   1'b0);
        check("cfg_noise_held", noise3, 1'b1);
        check("cfg_still_set",  cfg3,   1'b1);
        // P=6 is the smallest legal value: window 2..4.
        step(1'b1, 6, 0, 1'b1);
        check("cfg_clear", cfg3, 1'b0);
        for (int e = 1; e < 6; e++) begin
            step(1'b1, 6, e, 1'b1);
            if (e == 3) check("p6_ready_early", rdy3, 1'b0);
            if (e == 4) begin
                check("p6_ready", rdy3,   1'b1);
                check("p6_bit",   bit3,   1'b1);
                check("p6_noise", noise3, 1'b0);
            end
        end

        // Asynchronous reset in the middle of a bit.
        for (int e = 0; e < 8; e++) step(1'b1, 8, e, (e == 4));
        check("prerst_bit",   bit3,   1'b0);
        check("prerst_noise", noise3, 1'b1);
        for (int e = 0; e < 4; e++) step(1'b1, 8, e, 1'b0);
        drive(1'b1, 8, 4, 1'b0);
        rst = 1'b0;
        #2;
        check("arst_bit",   bit3,   1'b1);
        check("arst_ready", rdy3,   1'b0);
        check("arst_noise", noise3, 1'b0);
        check("arst_cfg",   cfg3,   1'b0);
        rst = 1'b1;
        #1;
        for (int e = 4; e < 8; e++) step(1'b0, 8, e, 1'b0);
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 8, e, 1'b0);
            if (e == 5) begin
                check("post_rst_ready", rdy3,   1'b1);
                check("post_rst_bit",   bit3,   1'b0);
                check("post_rst_noise", noise3, 1'b0);
            end
        end

        // Randomised bits against the reference model, both instances.
        drive(1'b0, 8, 0, 1'b1);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        for (int b = 0; b < 60; b++) begin
            int   p;
            int   drop;
            bit   skip;
            logic base;
            logic rx_v;
            logic en_v;
            p    = int'($urandom_range(4, 20));
            drop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, p - 1)) : p;
            skip = ($urandom_range(0, 9) == 0);
            base = 1'($urandom_range(0, 1));
            for (int e = 0; e < p; e++) begin
                if (skip && e == p / 2 + 1) continue;
                en_v = (e < drop);
                rx_v = base ^ ($urandom_range(0, 5) == 0);
                drive(en_v, p, e, rx_v);
                model_step(en_v, p, e, rx_v);
                tick();
                check($sformatf("rnd_b%0d_e%0d_n3_ready", b, e), rdy3,   m_rdy[0]);
                check($sformatf("rnd_b%0d_e%0d_n3_bit",   b, e), bit3,   m_bit[0]);
                check($sformatf("rnd_b%0d_e%0d_n3_noise", b, e), noise3, m_noise[0]);
                check($sformatf("rnd_b%0d_e%0d_n3_cfg",   b, e), cfg3,   m_cfg[0]);
                check($sformatf("rnd_b%0d_e%0d_n5_ready", b, e), rdy5,   m_rdy[1]);
                check($sformatf("rnd_b%0d_e%0d_n5_bit",   b, e), bit5,   m_bit[1]);
                check($sformatf("rnd_b%0d_e%0d_n5_noise", b, e), noise5, m_noise[1]);
                check($sformatf("rnd_b%0d_e%0d_n5_cfg",   b, e), cfg5,   m_cfg[1]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
